// File: rtl/rsa_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Package   : rsa_pkg                                               |
// | Purpose   : Shared types and constants for the modular-multiply   |
// |             execute unit (FSM state encoding, default datapath    |
// |             width, iterations per FSM phase).                     |
// | Revision  : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
package rsa_pkg;

  // Default operand / modulus / result width.
  localparam int unsigned MODMUL_WIDTH = 32;

  // Iterations spent in each of REDUCE and MULT at the default width
  // (one operand bit per iteration).
  localparam int unsigned MODMUL_ITERS = MODMUL_WIDTH;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REDUCE = 2'd1,
    MULT   = 2'd2,
    DONE   = 2'd3
  } modmul_state_e;

endpackage : rsa_pkg
`default_nettype wire

// File: rtl/modmul_step.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module    : modmul_step                                           |
// | Purpose   : One combinational modular iteration:                  |
// |               r_out = ((2*r_in mod n) + (add ? addend : 0)) mod n  |
// |             Requires r_in < n and addend <= n, so each reduction  |
// |             needs only a single conditional subtract.             |
// | Ports     : r_in     - running remainder (< n)                    |
// |             addend   - value added when add is set (<= n)         |
// |             n_in     - modulus (non-zero)                         |
// |             add      - add enable for this iteration              |
// |             r_out    - new remainder (< n)                        |
// | Revision  : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module modmul_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] r_in,
  input  logic [WIDTH-1:0] addend,
  input  logic [WIDTH-1:0] n_in,
  input  logic             add,
  output logic [WIDTH-1:0] r_out
);

  logic [WIDTH:0]   n_ext;
  logic [WIDTH:0]   dbl;
  logic [WIDTH-1:0] dbl_red;
  logic [WIDTH:0]   sum;

  assign n_ext = {1'b0, n_in};

  // 2*r < 2n, so one subtract brings it back below n; the reduced value
  // is below n and therefore fits in WIDTH bits.
  assign dbl     = {r_in, 1'b0};
  assign dbl_red = (dbl >= n_ext) ? WIDTH'(dbl - n_ext) : WIDTH'(dbl);

  // dbl_red < n and addend <= n, so the sum stays below 2n.
  assign sum   = {1'b0, dbl_red} + {1'b0, (add ? addend : {WIDTH{1'b0}})};
  assign r_out = (sum >= n_ext) ? WIDTH'(sum - n_ext) : WIDTH'(sum);

endmodule : modmul_step
`default_nettype wire

// File: rtl/ex_modmul_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module    : ex_modmul_unit                                        |
// | Purpose   : Multi-cycle (A*B) mod N unit for the execute stage.   |
// |             REDUCE computes A mod N by restoring shift-subtract,  |
// |             MULT runs MSB-first interleaved multiply-reduce; both |
// |             share one modmul_step. State changes on falling edge. |
// | Ports     : clk, rst (async, active-high)                         |
// |             startE/flushE      - issue / abort                    |
// |             rd1E, rd2E, modN   - operands A, B and modulus N      |
// |             WA3E / WA3M        - destination tag in / out         |
// |             stallE             - freeze request to IF/ID, ID/EX   |
// |             doneM, resultM, errM - result pulse, value, N==0 flag |
// | Revision  : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module ex_modmul_unit
  import rsa_pkg::*;
#(
  parameter int WIDTH = MODMUL_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             startE,
  input  logic             flushE,
  input  logic [WIDTH-1:0] rd1E,
  input  logic [WIDTH-1:0] rd2E,
  input  logic [WIDTH-1:0] modN,
  input  logic [3:0]       WA3E,
  output logic             stallE,
  output logic             doneM,
  output logic [WIDTH-1:0] resultM,
  output logic [3:0]       WA3M,
  output logic             errM
);

  // One operand bit is consumed per iteration in each phase.
  localparam int unsigned ITERS   = WIDTH;
  localparam int          CNT_W   = $clog2(ITERS);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ITERS - 1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  modmul_state_e    state_q,  state_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [WIDTH-1:0] a_q,      a_d;
  logic [WIDTH-1:0] b_q,      b_d;
  logic [WIDTH-1:0] n_q,      n_d;
  logic [3:0]       tag_q,    tag_d;
  logic [WIDTH-1:0] r_q,      r_d;
  logic [WIDTH-1:0] ared_q,   ared_d;
  logic             err_q,    err_d;
  logic             done_q,   done_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       wa3m_q,   wa3m_d;
  logic             errm_q,   errm_d;

  logic [WIDTH-1:0] step_addend;
  logic             step_add;
  logic [WIDTH-1:0] step_r;

  // REDUCE shifts A in one bit at a time (2R + bit == 2R + bit*1);
  // MULT adds Ared whenever the current B bit is set. A and B are kept
  // in shift registers so the MSB is always the current bit.
  assign step_addend = (state_q == REDUCE) ? ONE : ared_q;
  assign step_add    = (state_q == REDUCE) ? a_q[WIDTH-1] : b_q[WIDTH-1];

  modmul_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .r_in   (r_q),
    .addend (step_addend),
    .n_in   (n_q),
    .add    (step_add),
    .r_out  (step_r)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    n_d      = n_q;
    tag_d    = tag_q;
    r_d      = r_q;
    ared_d   = ared_q;
    err_d    = err_q;
    done_d   = 1'b0;
    result_d = result_q;
    wa3m_d   = wa3m_q;
    errm_d   = errm_q;

    if (flushE) begin
      // Abort from any state; a flush coincident with DONE also kills doneM.
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (startE) begin
            a_d   = rd1E;
            b_d   = rd2E;
            n_d   = modN;
            tag_d = WA3E;
            r_d   = '0;
            cnt_d = CNT_MAX;
            if (modN == '0) begin
              err_d   = 1'b1;
              state_d = DONE;
            end else begin
              err_d   = 1'b0;
              state_d = REDUCE;
            end
          end
        end
        REDUCE: begin
          r_d   = step_r;
          a_d   = a_q << 1;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == '0) begin
            ared_d  = step_r;
            r_d     = '0;
            cnt_d   = CNT_MAX;
            state_d = MULT;
          end
        end
        MULT: begin
          r_d   = step_r;
          b_d   = b_q << 1;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state_d = DONE;
          end
        end
        DONE: begin
          // R stays 0 on the N==0 path, giving resultM=0.
          done_d   = 1'b1;
          result_d = r_q;
          wa3m_d   = tag_q;
          errm_d   = err_q;
          state_d  = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      n_q      <= '0;
      tag_q    <= '0;
      r_q      <= '0;
      ared_q   <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      wa3m_q   <= '0;
      errm_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      n_q      <= n_d;
      tag_q    <= tag_d;
      r_q      <= r_d;
      ared_q   <= ared_d;
      err_q    <= err_d;
      done_q   <= done_d;
      result_q <= result_d;
      wa3m_q   <= wa3m_d;
      errm_q   <= errm_d;
    end
  end

  // Gated by rst so the freeze request drops the moment reset asserts.
  assign stallE  = ~rst & (((state_q == IDLE) & startE) |
                           (state_q == REDUCE) | (state_q == MULT));
  assign doneM   = done_q;
  assign resultM = result_q;
  assign WA3M    = wa3m_q;
  assign errM    = errm_q;

endmodule : ex_modmul_unit
`default_nettype wire

// File: doc/ex_modmul_unit.md
EX_MODMUL_UNIT -- requirements
Module: ex_modmul_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning the operand, modulus and result width.
REQ-002 SHALL have port clk, input, 1, pipeline clock; all state updates occur on the falling edge, matching the pipeline registers.
REQ-003 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-004 SHALL have port startE, input, 1, request from the execute stage to issue a modular multiply.
REQ-005 SHALL have port flushE, input, 1, abort of the in-flight operation.
REQ-006 SHALL have port rd1E, input, WIDTH, operand A.
REQ-007 SHALL have port rd2E, input, WIDTH, operand B.
REQ-008 SHALL have port modN, input, WIDTH, modulus N.
REQ-009 SHALL have port WA3E, input, 4, destination register tag.
REQ-010 SHALL have port stallE, output, 1, freeze request to IF/ID and ID/EX.
REQ-011 SHALL have port doneM, output, 1, one-cycle result-valid pulse.
REQ-012 SHALL have port resultM, output, WIDTH, (A*B) mod N.
REQ-013 SHALL have port WA3M, output, 4, tag of the completed result.
REQ-014 SHALL have port errM, output, 1, set with doneM when N==0.

Function
REQ-015 SHALL implement the FSM states IDLE, REDUCE, MULT and DONE.
REQ-016 In IDLE with startE=1, the unit SHALL latch A, B, N and WA3E and go to REDUCE, or to DONE with errM=1 and resultM=0 when N==0.
REQ-017 REDUCE SHALL run exactly WIDTH cycles of restoring shift-subtract, producing Ared = A mod N.
REQ-018 MULT SHALL run exactly WIDTH cycles of the interleaved step, bit i from MSB to LSB: R = 2R mod N, then if B[i]=1, R = (R+Ared) mod N.
REQ-019 Intermediate sums SHALL be held in WIDTH+1 bits, with a single conditional subtract per reduction, so R < N always.
REQ-020 DONE SHALL last one cycle with doneM=1, resultM=R and WA3M equal to the latched tag, then return to IDLE.
REQ-021 Latency SHALL be fixed: doneM asserted on the falling edge 2*WIDTH+1 edges after the edge that sampled startE (65 for WIDTH=32); the N==0 path gives doneM on the next edge.
REQ-022 stallE SHALL equal (startE & IDLE) | REDUCE | MULT, combinationally; it is 0 in DONE so the pipeline advances with the result.
REQ-023 startE outside IDLE SHALL be ignored, with no re-latch and no queueing.
REQ-024 flushE SHALL force IDLE on the next edge from any state with no doneM; flushE and startE together in IDLE means flush wins.
REQ-025 resultM, WA3M and errM SHALL hold their last DONE values until the next DONE.
REQ-026 N==1 SHALL give resultM=0 and errM=0 after full latency.

Reset
REQ-027 rst=1 SHALL immediately force IDLE, stallE=0, doneM=0, resultM=0, WA3M=0, errM=0, and clear all internal registers.
REQ-028 A reset mid-operation SHALL discard the operation with no doneM after release.

Structure
REQ-029 Package rsa_pkg SHALL hold the state enum type, the WIDTH default and the iteration-count constant.
REQ-030 One combinational sub-module, modmul_step, SHALL implement a single double/add/conditional-subtract iteration and be shared by REDUCE and MULT.

Verification
REQ-031 A=7, B=5, N=11, tag 3 -> doneM at edge 65, resultM=2, WA3M=3, errM=0, stallE high for 64 edges.
REQ-032 A=B=0xFFFFFFFF, N=0xFFFFFFFB -> resultM=16 (0x10).
REQ-033 N=0, A=9, B=9 -> doneM on the next edge, errM=1, resultM=0, stallE low after one cycle.
REQ-034 startE reasserted at edge 10 with new operands -> ignored; first result correct at edge 65 with no second doneM.
REQ-035 flushE at edge 30 of an operation -> IDLE, no doneM; new start A=3, B=4, N=5 -> resultM=2.
REQ-036 rst pulsed at edge 40 -> all outputs 0 immediately, no doneM after release; next A=2, B=3, N=1 -> resultM=0.
